// File: rtl/divisor_unit_cu.sv
// Control unit for the SRT radix-2 divider datapath: load, normalise, negate divisor,
// W carry-save iterations, resolve, sign-correct, de-normalise, then a one-cycle done.
module divisor_unit_cu #(
  parameter int parallelism = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       divisor_msb,
  input  logic       divisor_is_zero,
  input  logic       rem_sign,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero,
  output logic       divisor_en,
  output logic       divisor_lShift,
  output logic       notDIvisor_en,
  output logic       save_reminder,
  output logic       sumHMux_sel,
  output logic       sum_en,
  output logic       carry_en,
  output logic       QCorrectBitMux_sel,
  output logic       leftAddMode,
  output logic       rightAddMode,
  output logic       reminder_en,
  output logic       reminder_rShift,
  output logic       quotient_en,
  output logic [1:0] leftAddMux_sel,
  output logic [1:0] rightAddMux_sel
);

  localparam int CW = $clog2(parallelism) + 1;
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] LAST_IDX = CW'(parallelism - 1);

  // state  | meaning
  // IDLE   | waiting for start
  // LOAD   | capture divisor, clear sum/carry
  // NORM   | shift divisor left until its MSB is set, counting k
  // COMPL  | store the negated divisor
  // ITER   | W carry-save iterations
  // LAST   | resolve remainder and quotient from sum/carry
  // CORR   | restore remainder and decrement quotient if remainder negative
  // DENORM | shift remainder right k times
  // DONE   | one-cycle completion pulse
  typedef enum logic [3:0] {
    IDLE, LOAD, NORM, COMPL, ITER, LAST, CORR, DENORM, DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   kCnt;
  logic [CW-1:0]   iterCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      kCnt        <= '0;
      iterCnt     <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= LOAD;
            div_by_zero <= 1'b0;
          end
        end
        LOAD: begin
          kCnt    <= '0;
          iterCnt <= '0;
          if (divisor_is_zero) begin
            div_by_zero <= 1'b1;
            state       <= DONE;
          end else if (!divisor_msb) begin
            state <= NORM;
          end else begin
            state <= COMPL;
          end
        end
        NORM: begin
          // divisor_msb reflects the value after this cycle's shift, so exit on the same cycle
          if (kCnt != LAST_IDX) kCnt <= kCnt + ONE;
          if (divisor_msb || (kCnt >= LAST_IDX - ONE)) state <= COMPL;
        end
        COMPL: state <= ITER;
        ITER: begin
          if (iterCnt == LAST_IDX) state <= LAST;
          else                     iterCnt <= iterCnt + ONE;
        end
        LAST: state <= CORR;
        CORR: state <= (kCnt == '0) ? DONE : DENORM;
        DENORM: begin
          if (kCnt != '0) kCnt <= kCnt - ONE;
          if (kCnt <= ONE) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy               = (state != IDLE);
    done               = 1'b0;
    divisor_en         = 1'b0;
    divisor_lShift     = 1'b0;
    notDIvisor_en      = 1'b0;
    save_reminder      = 1'b0;
    sumHMux_sel        = 1'b0;
    sum_en             = 1'b0;
    carry_en           = 1'b0;
    QCorrectBitMux_sel = 1'b0;
    leftAddMode        = 1'b0;
    rightAddMode       = 1'b0;
    reminder_en        = 1'b0;
    reminder_rShift    = 1'b0;
    quotient_en        = 1'b0;
    leftAddMux_sel     = 2'b00;
    rightAddMux_sel    = 2'b00;
    case (state)
      LOAD: begin
        divisor_en = 1'b1;
        sum_en     = 1'b1;
        carry_en   = 1'b1;
      end
      NORM: begin
        divisor_en     = 1'b1;
        divisor_lShift = 1'b1;
      end
      COMPL: begin
        leftAddMux_sel = 2'b01;
        leftAddMode    = 1'b1;
        notDIvisor_en  = 1'b1;
      end
      ITER: begin
        sumHMux_sel = 1'b1;
        sum_en      = 1'b1;
        carry_en    = 1'b1;
      end
      LAST: begin
        save_reminder = 1'b1;
        reminder_en   = 1'b1;
        rightAddMode  = 1'b1;
        quotient_en   = 1'b1;
      end
      CORR: begin
        if (rem_sign) begin
          leftAddMux_sel  = 2'b10;
          reminder_en     = 1'b1;
          rightAddMux_sel = 2'b01;
          quotient_en     = 1'b1;
        end
      end
      DENORM: begin
        reminder_en     = 1'b1;
        reminder_rShift = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule
